// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates a CPU port and a DMA/loader port onto one
// single-port RAM. Each transfer runs IDLE -> ACCESS -> WAIT(xWAIT_CYCLES) -> DONE.
// The CPU has fixed priority. Defining ARB_STARVE_GUARD_EN adds a
// starvation guard: after STARVE_LIMIT consecutive CPU grants made while
// the DMA was waiting, the next contested arbitration goes to the DMA.
//
// state  | meaning
// IDLE   | no transfer in flight; arbitrate as soon as any request is present
// ACCESS | one cycle, RAM strobe (memRE or memWE) asserted with latched addr/data
// WAIT   | WAIT_CYCLES cycles, strobes low, address held; read data captured last cycle
// DONE   | one cycle, winner's DONE pulse high, then back to IDLE
module mem_arbiter #(
   parameter int AW           = 8,
   parameter int DW           = 8,
   parameter int WAIT_CYCLES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          cpuREAD,
   input  logic          cpuWRITE,
   input  logic [AW-1:0] cpuADDR,
   input  logic [DW-1:0] cpuDIN,
   output logic [DW-1:0] cpuDOUT,
   output logic          cpuDONE,
   output logic          cpuSTALL,
   input  logic          dmaREQ,
   input  logic          dmaWE,
   input  logic [AW-1:0] dmaADDR,
   input  logic [DW-1:0] dmaDIN,
   output logic [DW-1:0] dmaDOUT,
   output logic          dmaDONE,
   output logic          dmaGNT,
   output logic [AW-1:0] memADDR,
   output logic [DW-1:0] memDIN,
   input  logic [DW-1:0] memDOUT,
   output logic          memRE,
   output logic          memWE
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

   // the wait counter counts down to zero; zero marks the last WAIT cycle
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t        state_q;
   logic [3:0]    wait_q;
   logic          gnt_dma_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] din_q;
   logic [DW-1:0] cpu_dout_q;
   logic [DW-1:0] dma_dout_q;
   logic          cpu_done_q;
   logic          dma_done_q;
   logic          dma_gnt_q;
   logic          mem_re_q;
   logic          mem_we_q;

   logic          cpu_req;
   logic          any_req;
   logic          starve_hit;
   logic          pick_dma_d;
   logic          we_d;
   logic [AW-1:0] addr_d;
   logic [DW-1:0] din_d;

   assign cpu_req = cpuREAD | cpuWRITE;
   assign any_req = cpu_req | dmaREQ;

`ifdef ARB_STARVE_GUARD_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

   logic [3:0] starve_q;
   logic [3:0] starve_d;

   assign starve_hit = cpu_req & dmaREQ & (starve_q == STARVE_LIM);

   // count CPU grants that left the DMA waiting; any DMA grant or an
   // uncontested arbitration without dmaREQ restarts the count
   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE && any_req) begin
         if (pick_dma_d || !dmaREQ)
            starve_d = '0;
         else if (starve_q != 4'hF)
            starve_d = starve_q + 4'd1;
      end
   end

   // starvation counter register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         starve_q <= '0;
      else
         starve_q <= starve_d;
   end
`else
   logic [3:0] starve_limit_unused;

   assign starve_hit          = 1'b0;
   assign starve_limit_unused = 4'(STARVE_LIMIT);
`endif

   // arbitration: CPU wins unless only the DMA asks or the guard forces DMA;
   // a CPU asserting both read and write is treated as a write
   always_comb begin
      pick_dma_d = dmaREQ & (~cpu_req | starve_hit);
      we_d       = pick_dma_d ? dmaWE   : cpuWRITE;
      addr_d     = pick_dma_d ? dmaADDR : cpuADDR;
      din_d      = pick_dma_d ? dmaDIN  : cpuDIN;
   end

   // transfer FSM with all outputs registered
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= IDLE;
         wait_q     <= '0;
         gnt_dma_q  <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         din_q      <= '0;
         cpu_dout_q <= '0;
         dma_dout_q <= '0;
         cpu_done_q <= 1'b0;
         dma_done_q <= 1'b0;
         dma_gnt_q  <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         cpu_done_q <= 1'b0;
         dma_done_q <= 1'b0;
         mem_re_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q   <= ACCESS;
                  gnt_dma_q <= pick_dma_d;
                  we_q      <= we_d;
                  addr_q    <= addr_d;
                  din_q     <= din_d;
                  dma_gnt_q <= pick_dma_d;
                  mem_re_q  <= ~we_d;
                  mem_we_q  <= we_d;
               end
            end
            ACCESS: begin
               state_q <= WAIT;
               wait_q  <= WAIT_LOAD;
            end
            WAIT: begin
               if (wait_q == 4'd0) begin
                  state_q <= DONE;
                  if (!we_q) begin
                     if (gnt_dma_q)
                        dma_dout_q <= memDOUT;
                     else
                        cpu_dout_q <= memDOUT;
                  end
                  if (gnt_dma_q)
                     dma_done_q <= 1'b1;
                  else
                     cpu_done_q <= 1'b1;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            DONE: begin
               state_q   <= IDLE;
               dma_gnt_q <= 1'b0;
            end
            default: begin
               state_q   <= IDLE;
               dma_gnt_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpuDOUT  = cpu_dout_q;
   assign cpuDONE  = cpu_done_q;
   assign dmaDOUT  = dma_dout_q;
   assign dmaDONE  = dma_done_q;
   assign dmaGNT   = dma_gnt_q;
   assign memADDR  = addr_q;
   assign memDIN   = din_q;
   assign memRE    = mem_re_q;
   assign memWE    = mem_we_q;
   // stall is combinational so it is visible in the cycle the request appears;
   // reset masks it so every output is low while Rst is held
   assign cpuSTALL = cpu_req & ~cpu_done_q & ~Rst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM. Cycle 0 of each
// transaction is the IDLE cycle in which the request is first driven.
module tb_mem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int W  = 1;
   localparam int SL = 4;

   logic          Clk = 1'b0;
   logic          Rst = 1'b0;
   logic          cpuREAD = 1'b0, cpuWRITE = 1'b0;
   logic [AW-1:0] cpuADDR = '0;
   logic [DW-1:0] cpuDIN = '0;
   logic [DW-1:0] cpuDOUT;
   logic          cpuDONE, cpuSTALL;
   logic          dmaREQ = 1'b0, dmaWE = 1'b0;
   logic [AW-1:0] dmaADDR = '0;
   logic [DW-1:0] dmaDIN = '0;
   logic [DW-1:0] dmaDOUT;
   logic          dmaDONE, dmaGNT;
   logic [AW-1:0] memADDR;
   logic [DW-1:0] memDIN, memDOUT;
   logic          memRE, memWE;

   logic [DW-1:0] ram [0:255];
   logic          pre_we = 1'b0;
   logic [AW-1:0] pre_a = '0;
   logic [DW-1:0] pre_d = '0;

   int n_chk = 0;
   int n_err = 0;

   mem_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W), .STARVE_LIMIT(SL)) dut (
      .Clk(Clk), .Rst(Rst),
      .cpuREAD(cpuREAD), .cpuWRITE(cpuWRITE), .cpuADDR(cpuADDR), .cpuDIN(cpuDIN),
      .cpuDOUT(cpuDOUT), .cpuDONE(cpuDONE), .cpuSTALL(cpuSTALL),
      .dmaREQ(dmaREQ), .dmaWE(dmaWE), .dmaADDR(dmaADDR), .dmaDIN(dmaDIN),
      .dmaDOUT(dmaDOUT), .dmaDONE(dmaDONE), .dmaGNT(dmaGNT),
      .memADDR(memADDR), .memDIN(memDIN), .memDOUT(memDOUT),
      .memRE(memRE), .memWE(memWE)
   );

   always #5 Clk = ~Clk;

   assign memDOUT = ram[memADDR];

   always @(posedge Clk) begin
      if (pre_we)
         ram[pre_a] <= pre_d;
      else if (memWE)
         ram[memADDR] <= memDIN;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_all_zero(input string p);
      chk({p, "_cpuDOUT"}, cpuDOUT, 0);
      chk({p, "_dmaDOUT"}, dmaDOUT, 0);
      chk({p, "_memADDR"}, memADDR, 0);
      chk({p, "_memDIN"}, memDIN, 0);
      chk({p, "_ctl"}, {cpuDONE, dmaDONE, dmaGNT, memRE, memWE, cpuSTALL}, 0);
   endtask

   // single CPU read from IDLE: strobe at cycle 1, DONE at cycle 2+W
   task automatic cpu_read_check(input logic [7:0] a, input logic [7:0] e, input string p);
      cpuREAD = 1'b1;
      cpuADDR = a;
      #1;
      chk({p, "_stall_c0"}, cpuSTALL, 1);
      tick();
      chk({p, "_re_c1"}, {memRE, memWE}, 2'b10);
      chk({p, "_addr_c1"}, memADDR, a);
      chk({p, "_stall_c1"}, {cpuSTALL, cpuDONE}, 2'b10);
      tick();
      chk({p, "_wait_c2"}, {memRE, memWE, cpuSTALL, cpuDONE}, 4'b0010);
      tick();
      chk({p, "_done_c3"}, {cpuDONE, cpuSTALL}, 2'b10);
      chk({p, "_dout_c3"}, cpuDOUT, e);
      cpuREAD = 1'b0;
      tick();
      chk({p, "_done_c4"}, cpuDONE, 0);
      chk({p, "_hold_c4"}, cpuDOUT, e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int gnt, dn, rn, wn, cdn, ddn, n, first, last;
      int cdone, ddone;
      logic [5:0] seq;
      logic [5:0] seq_exp;

      // reset and RAM preload
      #1 Rst = 1'b1;
      pre_we = 1'b1; pre_a = 8'h12; pre_d = 8'hA5;
      tick();
      pre_we = 1'b0;
      tick();
      chk_all_zero("reset");
      chk("reset_state", dut.state_q, 0);

      // first arbitration right after release: CPU read 0x12 -> 0xA5
      Rst = 1'b0;
      cpu_read_check(8'h12, 8'hA5, "rd1");

      // DMA write 0x40 <- 0x3C
      dmaREQ = 1'b1; dmaWE = 1'b1; dmaADDR = 8'h40; dmaDIN = 8'h3C;
      tick();
      chk("dmawr_strobe", {memWE, memRE}, 2'b10);
      chk("dmawr_addr", memADDR, 8'h40);
      chk("dmawr_din", memDIN, 8'h3C);
      gnt = dmaGNT ? 1 : 0;
      dn = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (dmaGNT) gnt++;
         if (dmaDONE) begin dn++; dmaREQ = 1'b0; end
      end
      dmaWE = 1'b0;
      chk("dmawr_gnt_cycles", gnt, 2 + W);
      chk("dmawr_done_pulses", dn, 1);
      chk("dmawr_ram", ram[8'h40], 8'h3C);

      // simultaneous CPU read and DMA read: CPU first, DMA right after
      cpuREAD = 1'b1; cpuADDR = 8'h12;
      dmaREQ = 1'b1; dmaWE = 1'b0; dmaADDR = 8'h40;
      cdone = -1; ddone = -1; gnt = 0;
      for (int c = 0; c < 16; c++) begin
         if (cpuDONE) begin cdone = c; cpuREAD = 1'b0; end
         if (dmaDONE) begin ddone = c; dmaREQ = 1'b0; end
         if (dmaGNT) gnt++;
         tick();
      end
      chk("both_cpu_done_cyc", cdone, 2 + W);
      chk("both_dma_after_cpu", ddone - cdone, 3 + W);
      chk("both_dma_gnt_cycles", gnt, 2 + W);
      chk("both_cpu_dout", cpuDOUT, 8'hA5);
      chk("both_dma_dout", dmaDOUT, 8'h3C);

      // read and write together is a write
      cpuREAD = 1'b1; cpuWRITE = 1'b1; cpuADDR = 8'h55; cpuDIN = 8'h77;
      rn = 0; wn = 0; cdn = 0;
      for (int c = 0; c < 12; c++) begin
         if (memRE) rn++;
         if (memWE) wn++;
         if (cpuDONE) begin cdn++; cpuREAD = 1'b0; cpuWRITE = 1'b0; end
         tick();
      end
      chk("rw_no_memRE", rn, 0);
      chk("rw_one_memWE", wn, 1);
      chk("rw_one_done", cdn, 1);
      chk("rw_ram", ram[8'h55], 8'h77);
      cpu_read_check(8'h55, 8'h77, "rdback");
      chk("dma_dout_held", dmaDOUT, 8'h3C);

      // reset during WAIT of a CPU write
      cpuWRITE = 1'b1; cpuADDR = 8'h60; cpuDIN = 8'h99;
      tick();
      tick();
      chk("rstmid_in_wait", dut.state_q, 2);
      Rst = 1'b1;
      #1;
      chk_all_zero("rstmid");
      chk("rstmid_state", dut.state_q, 0);
      cpuWRITE = 1'b0;
      cdn = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (cpuDONE) cdn++;
      end
      chk("rstmid_no_done", cdn, 0);
      Rst = 1'b0;
      cpu_read_check(8'h12, 8'hA5, "post_rst");

      // both requesters held continuously: grant order and access spacing
      cpuREAD = 1'b1; cpuADDR = 8'h12;
      dmaREQ = 1'b1; dmaWE = 1'b0; dmaADDR = 8'h40;
      seq = '0; n = 0; first = -1; last = -1;
      for (int c = 0; c < 60 && n < 6; c++) begin
         if (memRE || memWE) begin
            seq[n] = dmaGNT;
            if (n == 0) first = c;
            last = c;
            n++;
         end
         tick();
      end
`ifdef ARB_STARVE_GUARD_EN
      seq_exp = 6'b010000;
`else
      seq_exp = 6'b000000;
`endif
      chk("seq_count", n, 6);
      chk("seq_grants", seq, seq_exp);
      chk("seq_spacing", last - first, 5 * (3 + W));

      // CPU drops mid-transfer: its transfer still completes, then DMA runs
      cpuREAD = 1'b0;
      cdn = 0; ddn = 0;
      for (int c = 0; c < 12; c++) begin
         if (cpuDONE) cdn++;
         if (dmaDONE) begin ddn++; dmaREQ = 1'b0; end
         tick();
      end
      chk("drop_cpu_done", cdn, 1);
      chk("drop_dma_done", ddn, 1);
      chk("drop_dma_dout", dmaDOUT, 8'h3C);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameters: AW, default 8, address width; DW, default 8, data width; WAIT_CYCLES, default 1, RAM wait states (legal range 1..15); STARVE_LIMIT, default 4, consecutive CPU grants tolerated while DMA waits (legal range 1..15).
REQ-002 Ports SHALL be (name  direction  width  meaning):
Clk  in  1  single clock, rising edge.
Rst  in  1  reset, asynchronous, active-high.
cpuREAD  in  1  control-unit read request, held until cpuDONE.
cpuWRITE  in  1  control-unit write request, held until cpuDONE.
cpuADDR  in  AW  CPU address.
cpuDIN  in  DW  CPU write data.
cpuDOUT  out  DW  CPU read data, registered.
cpuDONE  out  1  one-cycle CPU completion pulse.
cpuSTALL  out  1  high while a CPU request is pending and cpuDONE is low.
dmaREQ  in  1  DMA/loader request, held until dmaDONE.
dmaWE  in  1  DMA direction: 1 write, 0 read.
dmaADDR  in  AW  DMA address.
dmaDIN  in  DW  DMA write data.
dmaDOUT  out  DW  DMA read data, registered.
dmaDONE  out  1  one-cycle DMA completion pulse.
dmaGNT  out  1  high from ACCESS through DONE of a DMA transfer.
memADDR  out  AW  RAM address.
memDIN  out  DW  RAM write data.
memDOUT  in  DW  RAM read data.
memRE  out  1  RAM read strobe.
memWE  out  1  RAM write strobe.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE, and SHALL be reset to IDLE.
REQ-004 In IDLE with any request present, the block SHALL arbitrate, latch the winner, its address, data and direction, and go to ACCESS on the next edge.
REQ-005 Arbitration SHALL be fixed CPU priority, except as modified by REQ-015.
REQ-006 ACCESS SHALL last 1 cycle, drive memADDR/memDIN from the latched values, and assert exactly one of memRE/memWE.
REQ-007 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a 4-bit counter, with memADDR held and memRE/memWE low.
REQ-008 In the final WAIT cycle, read data SHALL be captured from memDOUT into the winner's DOUT register.
REQ-009 DONE SHALL last 1 cycle, pulse the winner's DONE, and then return to IDLE.
REQ-010 Latency SHALL be: request seen in IDLE at cycle N; DONE at cycle N+2+WAIT_CYCLES; minimum spacing between accesses is 3+WAIT_CYCLES cycles.
REQ-011 If cpuREAD and cpuWRITE are both high, the access SHALL be a write.
REQ-012 A request dropped after being granted SHALL still complete, with its DONE pulse issued.
REQ-013 Requests arriving outside IDLE SHALL wait; the loser of arbitration SHALL keep its request pending.
REQ-014 Each DOUT register SHALL hold its value until that requester's next read completes.

Reset
REQ-016 Asserting Rst SHALL immediately force: state IDLE; all outputs 0 (cpuDOUT, dmaDOUT, memADDR, memDIN = 0; cpuDONE, dmaDONE, dmaGNT, memRE, memWE, cpuSTALL = 0); wait and starvation counters 0.
REQ-017 Reset mid-transfer SHALL abort the transfer with no DONE pulse issued.
REQ-018 After Rst is released, the first arbitration SHALL occur on the first rising edge.

Configuration
REQ-015 With macro ARB_STARVE_GUARD_EN defined, the block SHALL:
- keep a 4-bit counter of consecutive CPU grants made while dmaREQ was high;
- clear the counter on a DMA grant, or when dmaREQ is low at arbitration;
- grant the DMA when the counter equals STARVE_LIMIT and both requesters are present.
Without the macro, the counter SHALL not exist and the CPU SHALL always win.

Verification
REQ-019 CPU read, WAIT_CYCLES=1, addr 0x12, RAM holds 0xA5 -> memRE high at cycle 1, cpuDONE at cycle 3, cpuDOUT=0xA5, cpuSTALL high in cycles 0-2.
REQ-020 DMA write addr 0x40, data 0x3C -> memWE with memADDR=0x40 and memDIN=0x3C in ACCESS; dmaGNT high for 1+WAIT_CYCLES+1 cycles; dmaDONE pulsed once.
REQ-021 cpuREAD and dmaREQ both rise in the same cycle, guard off -> CPU served first, DMA served immediately after, DMA done 3+WAIT_CYCLES cycles after CPU done.
REQ-022 Guard on, STARVE_LIMIT=4, CPU and DMA continuously requesting -> grant sequence CPU, CPU, CPU, CPU, DMA, CPU, ...
REQ-023 Rst asserted during WAIT of a CPU write -> all outputs 0 at once, no cpuDONE, state IDLE, a fresh read after release behaves as REQ-019.
REQ-024 cpuREAD and cpuWRITE both high, data 0x77 -> write performed, memRE never asserted, single cpuDONE.
